// File: rtl/dsp48a1_slice_if.sv
// Bus bundle for the dsp48a1_slice arithmetic slice.
// Carries the operand inputs, clock enables and result outputs. Clock and
// per-stage resets stay as plain ports on the slice itself.
//   master: drives operands/enables, receives results (e.g. a controller or bench)
//   slave : the slice itself
interface dsp48a1_slice_if;
  logic [17:0] A;
  logic [17:0] B;
  logic [17:0] BCIN;
  logic [17:0] D;
  logic [47:0] C;
  logic [47:0] PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P;
  logic [47:0] PCOUT;
  logic        CARRYOUT;
  logic        CARRYOUTF;

  modport master (
    output A, B, BCIN, D, C, PCIN, CARRYIN, OPMODE,
    output CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
    input  BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
  );

  modport slave (
    input  A, B, BCIN, D, C, PCIN, CARRYIN, OPMODE,
    input  CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
    output BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
  );
endinterface

// File: rtl/dsp48a1_slice.sv
// Behavioural Spartan-6 DSP48A1 slice: optional D+/-B pre-adder, 18x18
// unsigned multiplier, 48-bit post-adder/subtracter with X/Z muxes and carry.
// Every pipeline stage is an optional register (parameter = 1) or a wire (0).
// Ports:
//   clk                 rising-edge clock
//   RSTA..RSTOPMODE     per-stage asynchronous active-low resets
//   bus (slave)         operands A/B/BCIN/D/C/PCIN/CARRYIN/OPMODE, clock
//                       enables, results BCOUT/M/P/PCOUT/CARRYOUT/CARRYOUTF
module dsp48a1_slice #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input logic clk,
  input logic RSTA,
  input logic RSTB,
  input logic RSTC,
  input logic RSTD,
  input logic RSTM,
  input logic RSTP,
  input logic RSTCARRYIN,
  input logic RSTOPMODE,
  dsp48a1_slice_if.slave bus
);

  localparam bit B_DIRECT  = (B_INPUT == "DIRECT");
  localparam bit B_CASCADE = (B_INPUT == "CASCADE");
  localparam bit CIN_OP5   = (CARRYINSEL == "OPMODE5");
  localparam bit CIN_PORT  = (CARRYINSEL == "CARRYIN");

  logic [17:0] b_src, b0, b1, pre, a0, a1, d_val;
  logic [47:0] c_val, x_mux, z_mux, p_val;
  logic [35:0] mult, m_val;
  logic [7:0]  opm;
  logic [48:0] sum;
  logic        cin_sel, cin, cout;

  // ---------------- operand sources ----------------
  always_comb begin
    b_src = '0;
    if (B_DIRECT)       b_src = bus.B;
    else if (B_CASCADE) b_src = bus.BCIN;
  end

  always_comb begin
    cin_sel = 1'b0;
    if (CIN_OP5)       cin_sel = opm[5];
    else if (CIN_PORT) cin_sel = bus.CARRYIN;
  end

  // ---------------- input-stage registers ----------------
  if (A0REG != 0) begin : g_a0
    always_ff @(posedge clk or negedge RSTA)
      if (!RSTA)        a0 <= '0;
      else if (bus.CEA) a0 <= bus.A;
  end else begin : g_a0_w
    assign a0 = bus.A;
  end

  if (A1REG != 0) begin : g_a1
    always_ff @(posedge clk or negedge RSTA)
      if (!RSTA)        a1 <= '0;
      else if (bus.CEA) a1 <= a0;
  end else begin : g_a1_w
    assign a1 = a0;
  end

  if (B0REG != 0) begin : g_b0
    always_ff @(posedge clk or negedge RSTB)
      if (!RSTB)        b0 <= '0;
      else if (bus.CEB) b0 <= b_src;
  end else begin : g_b0_w
    assign b0 = b_src;
  end

  if (DREG != 0) begin : g_d
    always_ff @(posedge clk or negedge RSTD)
      if (!RSTD)        d_val <= '0;
      else if (bus.CED) d_val <= bus.D;
  end else begin : g_d_w
    assign d_val = bus.D;
  end

  if (CREG != 0) begin : g_c
    always_ff @(posedge clk or negedge RSTC)
      if (!RSTC)        c_val <= '0;
      else if (bus.CEC) c_val <= bus.C;
  end else begin : g_c_w
    assign c_val = bus.C;
  end

  if (OPMODEREG != 0) begin : g_op
    always_ff @(posedge clk or negedge RSTOPMODE)
      if (!RSTOPMODE)        opm <= '0;
      else if (bus.CEOPMODE) opm <= bus.OPMODE;
  end else begin : g_op_w
    assign opm = bus.OPMODE;
  end

  // ---------------- pre-adder and B1 stage ----------------
  always_comb begin
    pre = b0;
    if (opm[4]) pre = opm[6] ? (d_val - b0) : (d_val + b0);
  end

  if (B1REG != 0) begin : g_b1
    always_ff @(posedge clk or negedge RSTB)
      if (!RSTB)        b1 <= '0;
      else if (bus.CEB) b1 <= pre;
  end else begin : g_b1_w
    assign b1 = pre;
  end

  // ---------------- multiplier and M stage ----------------
  assign mult = {18'd0, a1} * {18'd0, b1};

  if (MREG != 0) begin : g_m
    always_ff @(posedge clk or negedge RSTM)
      if (!RSTM)        m_val <= '0;
      else if (bus.CEM) m_val <= mult;
  end else begin : g_m_w
    assign m_val = mult;
  end

  // ---------------- carry-in stage ----------------
  if (CARRYINREG != 0) begin : g_cin
    always_ff @(posedge clk or negedge RSTCARRYIN)
      if (!RSTCARRYIN)        cin <= 1'b0;
      else if (bus.CECARRYIN) cin <= cin_sel;
  end else begin : g_cin_w
    assign cin = cin_sel;
  end

  // ---------------- X/Z muxes and post-adder ----------------
  always_comb begin
    x_mux = '0;
    case (opm[1:0])
      2'd1:    x_mux = {12'd0, m_val};
      2'd2:    x_mux = p_val;
      2'd3:    x_mux = {d_val[11:0], a1, b1};
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (opm[3:2])
      2'd1:    z_mux = bus.PCIN;
      2'd2:    z_mux = p_val;
      2'd3:    z_mux = c_val;
      default: z_mux = '0;
    endcase
  end

  // Subtract mode folds the carry into X before subtracting, so bit 48
  // acts as a borrow flag in that mode.
  always_comb begin
    sum = '0;
    if (opm[7]) sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin});
    else        sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin};
  end

  // ---------------- P and carry-out stages ----------------
  if (PREG != 0) begin : g_p
    always_ff @(posedge clk or negedge RSTP)
      if (!RSTP)        p_val <= '0;
      else if (bus.CEP) p_val <= sum[47:0];
  end else begin : g_p_w
    assign p_val = sum[47:0];
  end

  // Carry-out shares the P reset but is enabled with the carry-in stage.
  if (CARRYOUTREG != 0) begin : g_co
    always_ff @(posedge clk or negedge RSTP)
      if (!RSTP)              cout <= 1'b0;
      else if (bus.CECARRYIN) cout <= sum[48];
  end else begin : g_co_w
    assign cout = sum[48];
  end

  // ---------------- outputs ----------------
  assign bus.BCOUT     = b1;
  assign bus.M         = m_val;
  assign bus.P         = p_val;
  assign bus.PCOUT     = p_val;
  assign bus.CARRYOUT  = cout;
  assign bus.CARRYOUTF = cout;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice at default parameters. Stimulus pushes
// expected output values tagged with the cycle they are due; a monitor pops
// and compares them on the falling edge of that cycle.
module tb_dsp48a1_slice;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c, rst_d, rst_m, rst_p, rst_cin, rst_op;

  dsp48a1_slice_if bus();

  dsp48a1_slice #(
    .A0REG(0), .A1REG(1), .B0REG(0), .B1REG(1), .CREG(1), .DREG(1),
    .MREG(1), .PREG(1), .CARRYINREG(1), .CARRYOUTREG(1), .OPMODEREG(1),
    .CARRYINSEL("OPMODE5"), .B_INPUT("DIRECT")
  ) dut (
    .clk(clk),
    .RSTA(rst_a), .RSTB(rst_b), .RSTC(rst_c), .RSTD(rst_d),
    .RSTM(rst_m), .RSTP(rst_p), .RSTCARRYIN(rst_cin), .RSTOPMODE(rst_op),
    .bus(bus)
  );

  always #5 clk = ~clk;

  localparam int unsigned S_BC = 0, S_M = 1, S_P = 2, S_PC = 3, S_CO = 4, S_COF = 5;

  typedef struct {
    int unsigned due;
    int unsigned sel;
    logic [47:0] val;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] out_val(int unsigned sel);
    case (sel)
      S_BC:    return {30'd0, bus.BCOUT};
      S_M:     return {12'd0, bus.M};
      S_P:     return bus.P;
      S_PC:    return bus.PCOUT;
      S_CO:    return {47'd0, bus.CARRYOUT};
      default: return {47'd0, bus.CARRYOUTF};
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_t        e;
        string       nm;
        logic [47:0] act;
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = out_val(e.sel);
        n_vec++;
        if (e.due != cyc) begin
          n_bad++;
          $display("FAIL %s: due cycle %0d, checked late at cycle %0d", nm, e.due, cyc);
        end else if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, act, e.val);
        end
      end
    end
  end

  task automatic push(int unsigned dly, int unsigned sel, logic [47:0] v, string nm);
    exp_t e;
    e.due = cyc + dly;
    e.sel = sel;
    e.val = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk_all(int unsigned dly, logic [17:0] bc, logic [35:0] m,
                         logic [47:0] p, logic co, string tag);
    push(dly, S_BC,  {30'd0, bc}, {tag, ".BCOUT"});
    push(dly, S_M,   {12'd0, m},  {tag, ".M"});
    push(dly, S_P,   p,           {tag, ".P"});
    push(dly, S_PC,  p,           {tag, ".PCOUT"});
    push(dly, S_CO,  {47'd0, co}, {tag, ".CARRYOUT"});
    push(dly, S_COF, {47'd0, co}, {tag, ".CARRYOUTF"});
  endtask

  task automatic tick(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rst(logic v);
    rst_a = v; rst_b = v; rst_c = v; rst_d = v;
    rst_m = v; rst_p = v; rst_cin = v; rst_op = v;
  endtask

  task automatic set_ce(logic v);
    bus.CEA = v; bus.CEB = v; bus.CEC = v; bus.CED = v;
    bus.CEM = v; bus.CEP = v; bus.CECARRYIN = v; bus.CEOPMODE = v;
  endtask

  task automatic rand_in();
    bus.A       = 18'($urandom);
    bus.B       = 18'($urandom);
    bus.BCIN    = 18'($urandom);
    bus.D       = 18'($urandom);
    bus.C       = {16'($urandom), $urandom};
    bus.PCIN    = {16'($urandom), $urandom};
    bus.CARRYIN = 1'($urandom);
    bus.OPMODE  = 8'($urandom);
  endtask

  task automatic apply(logic [17:0] a, logic [17:0] b, logic [17:0] d,
                       logic [47:0] c, logic [7:0] op);
    bus.A = a; bus.B = b; bus.D = d; bus.C = c; bus.OPMODE = op;
    bus.BCIN = '0; bus.PCIN = '0; bus.CARRYIN = 1'b0;
  endtask

  initial begin : stim
    set_rst(1'b1);
    set_ce(1'b1);
    rand_in();
    tick(2);

    // Asynchronous reset assertion mid-cycle, random inputs while held.
    #2;
    set_rst(1'b0);
    chk_all(0, 18'd0, 36'd0, 48'd0, 1'b0, "rst_assert");
    tick(1);
    rand_in();
    chk_all(0, 18'd0, 36'd0, 48'd0, 1'b0, "rst_held");
    tick(1);

    // Release mid-cycle with the first transaction on the inputs.
    #2;
    apply(18'd3, 18'd4, 18'd0, 48'd0, 8'h01);
    set_rst(1'b1);
    push(1, S_BC, 48'd4,  "lat.BCOUT_1");
    push(1, S_M,  48'd0,  "lat.M_1");
    push(2, S_M,  48'd12, "lat.M_2");
    push(2, S_P,  48'd0,  "lat.P_2");
    push(3, S_P,  48'd12, "lat.P_3");
    push(3, S_PC, 48'd12, "lat.PCOUT_3");
    push(3, S_CO, 48'd0,  "lat.CARRYOUT_3");
    tick(3);
    chk_all(2, 18'd4, 36'd12, 48'd12, 1'b0, "mul_hold");
    tick(2);

    // Pre-adder.
    apply(18'd2, 18'd3, 18'd10, 48'd0, 8'h11);
    chk_all(6, 18'd13, 36'd26, 48'd26, 1'b0, "pre_add");
    tick(6);
    apply(18'd2, 18'd3, 18'd10, 48'd0, 8'h51);
    chk_all(6, 18'd7, 36'd14, 48'd14, 1'b0, "pre_sub");
    tick(6);

    // Post-adder with C.
    apply(18'd2, 18'd3, 18'd0, 48'd100, 8'h0D);
    chk_all(6, 18'd3, 36'd6, 48'd106, 1'b0, "post_add");
    tick(6);
    apply(18'd2, 18'd3, 18'd0, 48'd100, 8'h2D);
    chk_all(6, 18'd3, 36'd6, 48'd107, 1'b0, "post_add_cin");
    tick(6);
    apply(18'd2, 18'd3, 18'd0, 48'd100, 8'h8D);
    chk_all(6, 18'd3, 36'd6, 48'd94, 1'b0, "post_sub");
    tick(6);

    // Accumulate: settle P = M = 1, then feed P back through Z.
    apply(18'd1, 18'd1, 18'd0, 48'd0, 8'h01);
    chk_all(6, 18'd1, 36'd1, 48'd1, 1'b0, "acc_seed");
    tick(6);
    bus.OPMODE = 8'h09;
    for (int unsigned k = 1; k <= 5; k++)
      push(k, S_P, 48'(k), $sformatf("acc.P_%0d", k));
    tick(5);

    // X concatenation {D[11:0], A, B}.
    apply(18'd0, 18'd0, 18'd1, 48'd0, 8'h03);
    chk_all(6, 18'd0, 36'd0, 48'h0010_0000_0000, 1'b0, "concat");
    tick(6);

    // Carry-out.
    apply(18'd0, 18'd0, 18'd0, 48'd0, 8'h8C);
    chk_all(6, 18'd0, 36'd0, 48'd0, 1'b0, "co_sub_zero");
    tick(6);
    apply(18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 8'h2C);
    chk_all(6, 18'd0, 36'd0, 48'd0, 1'b1, "co_wrap");
    tick(6);

    // Negative result with borrow, then freeze with all enables low.
    apply(18'd5, 18'd7, 18'd0, 48'd10, 8'h8D);
    chk_all(6, 18'd7, 36'd35, 48'hFFFF_FFFF_FFE7, 1'b1, "borrow");
    tick(6);
    set_ce(1'b0);
    apply(18'd9, 18'd9, 18'd5, 48'd0, 8'h01);
    bus.CARRYIN = 1'b1;
    chk_all(1, 18'd7, 36'd35, 48'hFFFF_FFFF_FFE7, 1'b1, "ce_hold_1");
    chk_all(4, 18'd7, 36'd35, 48'hFFFF_FFFF_FFE7, 1'b1, "ce_hold_4");
    tick(4);
    set_ce(1'b1);
    chk_all(6, 18'd9, 36'd81, 48'd81, 1'b0, "ce_resume");
    tick(6);

    // Drain the scoreboard within a bounded number of cycles.
    for (int unsigned w = 0; w < 20 && exp_q.size() > 0; w++) tick(1);
    while (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never checked, due cycle %0d, now %0d", nm, e.due, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_bad);
    $fatal(1, "timeout");
  end

endmodule
